// File: rtl/rf_pkg.sv
// Shared constants for the register-file writeback path.
package rf_pkg;
  localparam int unsigned AW       = 5;
  localparam int unsigned DW       = 32;
  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned SRC_ALU  = 0;
  localparam int unsigned SRC_MEM  = 1;
endpackage

// File: rtl/wb_slot.sv
// One-entry writeback holding register: a new accept may reload the slot on its grant edge.
module wb_slot #(
  parameter int unsigned AW = rf_pkg::AW,
  parameter int unsigned DW = rf_pkg::DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_v,
  input  logic [AW-1:0] req_a,
  input  logic [DW-1:0] req_d,
  input  logic          grant,
  input  logic          stamp,
  output logic          rdy,
  output logic          valid,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data,
  output logic          seq
);
  logic          valid_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;
  logic          seq_q;
  logic          accept;

  assign rdy    = !valid_q | grant;
  assign accept = req_v & rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      seq_q   <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      addr_q  <= req_a;
      data_q  <= req_d;
      seq_q   <= stamp;
    end else if (grant) begin
      valid_q <= 1'b0;
    end
  end

  assign valid = valid_q;
  assign addr  = addr_q;
  assign data  = data_q;
  assign seq   = seq_q;
endmodule

// File: rtl/reg_wr_arbiter.sv
// Two-source, age-ordered round-robin arbiter onto the single register-file write port,
// with pending-write flags for the two read addresses.
module reg_wr_arbiter #(
  parameter int unsigned AW        = rf_pkg::AW,
  parameter int unsigned DW        = rf_pkg::DW,
  parameter bit          ZERO_DROP = 1'b1
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          ReqV0,
  input  logic [AW-1:0] ReqA0,
  input  logic [DW-1:0] ReqD0,
  output logic          ReqRdy0,
  input  logic          ReqV1,
  input  logic [AW-1:0] ReqA1,
  input  logic [DW-1:0] ReqD1,
  output logic          ReqRdy1,
  output logic [AW-1:0] Awr,
  output logic [DW-1:0] Din,
  output logic          WrEn,
  input  logic [AW-1:0] Ard1,
  input  logic [AW-1:0] Ard2,
  output logic          Pend1,
  output logic          Pend2,
  output logic          Idle
);
  import rf_pkg::*;

  logic          v0, v1, s0, s1, g0, g1, sel, any, tie, same_nz;
  logic [AW-1:0] a0, a1, wr_a;
  logic [DW-1:0] d0, d1, wr_d;
  logic          age_q, rr_q, wren_q;
  logic [AW-1:0] awr_q;
  logic [DW-1:0] din_q;

  wb_slot #(.AW(AW), .DW(DW)) u_slot0 (
    .clk   (Clk),
    .rst_n (Rst_n),
    .req_v (ReqV0),
    .req_a (ReqA0),
    .req_d (ReqD0),
    .grant (g0),
    .stamp (age_q),
    .rdy   (ReqRdy0),
    .valid (v0),
    .addr  (a0),
    .data  (d0),
    .seq   (s0)
  );

  wb_slot #(.AW(AW), .DW(DW)) u_slot1 (
    .clk   (Clk),
    .rst_n (Rst_n),
    .req_v (ReqV1),
    .req_a (ReqA1),
    .req_d (ReqD1),
    .grant (g1),
    .stamp (age_q),
    .rdy   (ReqRdy1),
    .valid (v1),
    .addr  (a1),
    .data  (d1),
    .seq   (s1)
  );

  assign tie     = v0 & v1 & (s0 == s1);
  assign same_nz = (a0 == a1) & (a0 != AW'(REG_ZERO));
  assign any     = v0 | v1;

  // The newest entry carries the complement of age_q, so the older one matches it.
  always_comb begin
    sel = 1'(SRC_ALU);
    if (v0 & v1) begin
      if (s0 != s1)     sel = (s0 == age_q) ? 1'(SRC_ALU) : 1'(SRC_MEM);
      else if (!same_nz) sel = rr_q;
    end else if (v1) begin
      sel = 1'(SRC_MEM);
    end
  end

  assign g0   = v0 & (sel == 1'(SRC_ALU));
  assign g1   = v1 & (sel == 1'(SRC_MEM));
  assign wr_a = sel ? a1 : a0;
  assign wr_d = sel ? d1 : d0;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      awr_q  <= '0;
      din_q  <= '0;
      wren_q <= 1'b0;
      rr_q   <= 1'b0;
      age_q  <= 1'b0;
    end else begin
      wren_q <= 1'b0;
      if (any) begin
        awr_q  <= wr_a;
        din_q  <= wr_d;
        wren_q <= (wr_a != AW'(REG_ZERO)) | !ZERO_DROP;
      end
      if (tie) rr_q <= ~rr_q;
      if ((ReqV0 & ReqRdy0) | (ReqV1 & ReqRdy1)) age_q <= ~age_q;
    end
  end

  assign Awr  = awr_q;
  assign Din  = din_q;
  assign WrEn = wren_q;

  assign Pend1 = (Ard1 != AW'(REG_ZERO)) &
                 ((v0 & (a0 == Ard1)) | (v1 & (a1 == Ard1)) | (wren_q & (awr_q == Ard1)));
  assign Pend2 = (Ard2 != AW'(REG_ZERO)) &
                 ((v0 & (a0 == Ard2)) | (v1 & (a1 == Ard2)) | (wren_q & (awr_q == Ard2)));
  assign Idle  = !v0 & !v1 & !wren_q;
endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Directed bench for reg_wr_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_reg_wr_arbiter;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic          Clk = 1'b0;
  logic          Rst_n;
  logic          ReqV0, ReqV1, ReqRdy0, ReqRdy1, WrEn, Pend1, Pend2, Idle;
  logic [AW-1:0] ReqA0, ReqA1, Awr, Ard1, Ard2;
  logic [DW-1:0] ReqD0, ReqD1, Din;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  typedef struct {
    logic          v0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          v1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    int            n;
    wr_t           e0;
    wr_t           e1;
  } vec_t;

  vec_t          vecs [8];
  wr_t           q_obs [$];
  wr_t           q_exp0 [$];
  wr_t           q_exp1 [$];
  logic [DW-1:0] rf [32];

  always #5 Clk = ~Clk;

  reg_wr_arbiter #(.AW(AW), .DW(DW), .ZERO_DROP(1'b1)) dut (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .ReqV0   (ReqV0),
    .ReqA0   (ReqA0),
    .ReqD0   (ReqD0),
    .ReqRdy0 (ReqRdy0),
    .ReqV1   (ReqV1),
    .ReqA1   (ReqA1),
    .ReqD1   (ReqD1),
    .ReqRdy1 (ReqRdy1),
    .Awr     (Awr),
    .Din     (Din),
    .WrEn    (WrEn),
    .Ard1    (Ard1),
    .Ard2    (Ard2),
    .Pend1   (Pend1),
    .Pend2   (Pend2),
    .Idle    (Idle)
  );

  // Register-file model and write monitor.
  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (WrEn) begin
      rf[Awr] <= Din;
    end
  end

  always @(posedge Clk) begin
    if (Rst_n && WrEn) q_obs.push_back('{a: Awr, d: Din});
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    ReqV0 = v0; ReqA0 = a0; ReqD0 = d0;
    ReqV1 = v1; ReqA1 = a1; ReqD1 = d1;
  endtask

  initial begin
    int base, n, bad, wcnt, acc0, acc1, cnt0, cnt1;
    logic r0, r1;
    wr_t w, e;

    // rr_ptr state assumed at each tie is noted per row.
    vecs[0] = '{1'b1, 5'd3,  32'h11, 1'b0, 5'd0,  32'h0,  1, '{5'd3, 32'h11}, '{5'd0, 32'h0}};
    vecs[1] = '{1'b1, 5'd10, 32'h2,  1'b1, 5'd5,  32'h9,  2, '{5'd10, 32'h2}, '{5'd5, 32'h9}};  // rr0
    vecs[2] = '{1'b1, 5'd10, 32'h2,  1'b1, 5'd5,  32'h9,  2, '{5'd5, 32'h9}, '{5'd10, 32'h2}};  // rr1
    vecs[3] = '{1'b0, 5'd0,  32'h0,  1'b1, 5'd0,  32'h9,  0, '{5'd0, 32'h0}, '{5'd0, 32'h0}};
    vecs[4] = '{1'b1, 5'd0,  32'h5,  1'b1, 5'd12, 32'h6,  1, '{5'd12, 32'h6}, '{5'd0, 32'h0}};  // rr0
    vecs[5] = '{1'b0, 5'd0,  32'h0,  1'b1, 5'd31, 32'hFFFF_FFFF, 1,
                '{5'd31, 32'hFFFF_FFFF}, '{5'd0, 32'h0}};
    vecs[6] = '{1'b1, 5'd0,  32'h4,  1'b1, 5'd0,  32'h8,  0, '{5'd0, 32'h0}, '{5'd0, 32'h0}};  // rr1
    vecs[7] = '{1'b1, 5'd7,  32'h1,  1'b1, 5'd7,  32'h2,  2, '{5'd7, 32'h1}, '{5'd7, 32'h2}};

    // Reset held with a request present.
    Rst_n = 1'b0;
    Ard1 = '0; Ard2 = '0;
    drive(1'b1, 5'd4, 32'h5, 1'b0, 5'd0, 32'h0);
    repeat (3) step();
    check("rst_wren", 32'(WrEn), 32'd0);
    check("rst_awr", 32'(Awr), 32'd0);
    check("rst_din", Din, 32'd0);
    check("rst_idle", 32'(Idle), 32'd1);
    @(negedge Clk);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    Rst_n = 1'b1;
    #1;
    check("rst_rdy0", 32'(ReqRdy0), 32'd1);
    check("rst_rdy1", 32'(ReqRdy1), 32'd1);
    check("rst_pend1", 32'(Pend1), 32'd0);
    step();
    check("rst_no_write", 32'(q_obs.size()), 32'd0);

    // Single write latency and Pend on the second read port.
    Ard2 = 5'd3;
    drive(1'b1, 5'd3, 32'd32, 1'b0, 5'd0, 32'h0);
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    check("single_wren_n", 32'(WrEn), 32'd0);
    check("single_pend2_slot", 32'(Pend2), 32'd1);
    step();
    check("single_wren", 32'(WrEn), 32'd1);
    check("single_awr", 32'(Awr), 32'd3);
    check("single_din", Din, 32'd32);
    check("single_pend2_out", 32'(Pend2), 32'd1);
    step();
    check("single_wren_drop", 32'(WrEn), 32'd0);
    check("single_rf3", rf[3], 32'd32);
    check("single_pend2_clr", 32'(Pend2), 32'd0);
    Ard2 = '0;

    // Vector table.
    for (int i = 0; i < 8; i++) begin
      base = q_obs.size();
      drive(vecs[i].v0, vecs[i].a0, vecs[i].d0, vecs[i].v1, vecs[i].a1, vecs[i].d1);
      step();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      repeat (4) step();
      n = q_obs.size() - base;
      check($sformatf("vec%0d_count", i), 32'(n), 32'(vecs[i].n));
      if (vecs[i].n >= 1 && n >= 1) begin
        check($sformatf("vec%0d_w0_a", i), 32'(q_obs[base].a), 32'(vecs[i].e0.a));
        check($sformatf("vec%0d_w0_d", i), q_obs[base].d, vecs[i].e0.d);
      end
      if (vecs[i].n >= 2 && n >= 2) begin
        check($sformatf("vec%0d_w1_a", i), 32'(q_obs[base+1].a), 32'(vecs[i].e1.a));
        check($sformatf("vec%0d_w1_d", i), q_obs[base+1].d, vecs[i].e1.d);
      end
      check($sformatf("vec%0d_idle", i), 32'(Idle), 32'd1);
    end
    check("rf_reg0", rf[0], 32'd0);
    check("rf_reg3", rf[3], 32'h11);
    check("rf_reg7", rf[7], 32'h2);
    check("rf_reg10", rf[10], 32'h2);
    check("rf_reg12", rf[12], 32'h6);
    check("rf_reg31", rf[31], 32'hFFFF_FFFF);

    // Same-address tie with Pend1 tracking register 7.
    Ard1 = 5'd7; Ard2 = 5'd5;
    drive(1'b1, 5'd7, 32'h33, 1'b1, 5'd7, 32'h44);
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    check("tie7_pend1_a", 32'(Pend1), 32'd1);
    check("tie7_pend2_a", 32'(Pend2), 32'd0);
    step();
    check("tie7_pend1_b", 32'(Pend1), 32'd1);
    check("tie7_first_d", Din, 32'h33);
    step();
    check("tie7_pend1_c", 32'(Pend1), 32'd1);
    check("tie7_second_d", Din, 32'h44);
    step();
    check("tie7_wren_drop", 32'(WrEn), 32'd0);
    check("tie7_pend1_clr", 32'(Pend1), 32'd0);
    check("tie7_rf7", rf[7], 32'h44);

    // $0 write from src1 is retired without WrEn.
    Ard1 = '0; Ard2 = '0;
    base = q_obs.size();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h9);
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    check("zero_pend1", 32'(Pend1), 32'd0);
    check("zero_busy", 32'(Idle), 32'd0);
    check("zero_rdy1", 32'(ReqRdy1), 32'd1);
    step();
    check("zero_wren", 32'(WrEn), 32'd0);
    check("zero_idle", 32'(Idle), 32'd1);
    step();
    check("zero_no_write", 32'(q_obs.size() - base), 32'd0);
    check("zero_rf0", rf[0], 32'd0);

    // Back-pressure: both sources always valid, fresh data per accept.
    base = q_obs.size();
    cnt0 = 0; cnt1 = 0; wcnt = 0; acc0 = 0; acc1 = 0;
    drive(1'b1, 5'd1, 32'h0, 1'b1, 5'd2, 32'h8000_0000);
    for (int i = 0; i < 24; i++) begin
      @(negedge Clk);
      r0 = ReqRdy0;
      r1 = ReqRdy1;
      if (i >= 2) check($sformatf("bp_one_rdy%0d", i), 32'(r0) + 32'(r1), 32'd1);
      if (i >= 3 && WrEn) wcnt++;
      @(posedge Clk);
      #1;
      if (r0) begin
        q_exp0.push_back('{a: ReqA0, d: ReqD0});
        acc0++; cnt0++;
        ReqA0 = AW'(1 + cnt0 % 30);
        ReqD0 = 32'(cnt0);
      end
      if (r1) begin
        q_exp1.push_back('{a: ReqA1, d: ReqD1});
        acc1++; cnt1++;
        ReqA1 = AW'(1 + (cnt1 + 7) % 30);
        ReqD1 = 32'h8000_0000 | 32'(cnt1);
      end
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    repeat (5) step();
    check("bp_throughput", 32'(wcnt), 32'd21);
    check("bp_total", 32'(q_obs.size() - base), 32'(acc0 + acc1));
    bad = 0;
    for (int j = base; j < q_obs.size(); j++) begin
      w = q_obs[j];
      if (w.d[31]) begin
        if (q_exp1.size() == 0) bad++;
        else begin e = q_exp1.pop_front(); if (e != w) bad++; end
      end else begin
        if (q_exp0.size() == 0) bad++;
        else begin e = q_exp0.pop_front(); if (e != w) bad++; end
      end
    end
    check("bp_order", 32'(bad), 32'd0);
    check("bp_leftover", 32'(q_exp0.size() + q_exp1.size()), 32'd0);

    // Reset mid-operation with both slots loaded.
    drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd11, 32'hAA);
    repeat (4) step();
    #1;
    check("midrst_pre_wren", 32'(WrEn), 32'd1);
    Ard1 = Awr;
    Rst_n = 1'b0;
    #1;
    check("midrst_wren", 32'(WrEn), 32'd0);
    check("midrst_idle", 32'(Idle), 32'd1);
    check("midrst_pend1", 32'(Pend1), 32'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge Clk);
    Rst_n = 1'b1;
    base = q_obs.size();
    repeat (5) step();
    check("midrst_no_stale", 32'(q_obs.size() - base), 32'd0);
    check("midrst_idle_after", 32'(Idle), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
